// File: rtl/neural_layer_engine_if.sv
// rtl/neural_layer_engine_if.sv - memory-side bus of the layer engine (instruction ROM, weight ROM, neuron RAM)
interface neural_layer_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] instr_addr;
    logic [ADDR_W-1:0] instr_data;
    logic [ADDR_W-1:0] weight_addr;
    logic [DATA_W-1:0] weight_data;
    logic [ADDR_W-1:0] nram_rd_addr;
    logic [DATA_W-1:0] nram_rd_data;
    logic [ADDR_W-1:0] nram_wr_addr;
    logic [DATA_W-1:0] nram_wr_data;
    logic              nram_wr_en;

    modport master (
        output instr_addr, weight_addr, nram_rd_addr, nram_wr_addr, nram_wr_data, nram_wr_en,
        input  instr_data, weight_data, nram_rd_data
    );

    modport slave (
        input  instr_addr, weight_addr, nram_rd_addr, nram_wr_addr, nram_wr_data, nram_wr_en,
        output instr_data, weight_data, nram_rd_data
    );
endinterface

// File: rtl/neural_layer_engine.sv
// rtl/neural_layer_engine.sv - fully-connected layer sequencer with ping-pong neuron banks
// Define NEURAL_LAYER_ENGINE_RELU_EN to clamp negative outputs to zero (ReLU); default is linear.
module neural_layer_engine #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int FRAC_BITS    = 0,
    parameter int RW_BASE_LOW  = 0,
    parameter int RW_BASE_HIGH = 20,
    parameter logic [ADDR_W-1:0] END_OF_PROGRAM = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    neural_layer_engine_if.master mem,
    input  logic [ADDR_W-1:0] ext_rd_addr,
    input  logic [ADDR_W-1:0] ext_wr_addr,
    input  logic [DATA_W-1:0] ext_wr_data,
    input  logic              ext_wr_en,
    output logic [DATA_W-1:0] ext_rd_data,
    output logic [ADDR_W-1:0] result_base,
    output logic [ADDR_W-1:0] result_count
);
    localparam int ACC_W = 2 * DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_LO = ADDR_W'(RW_BASE_LOW);
    localparam logic [ADDR_W-1:0] BASE_HI = ADDR_W'(RW_BASE_HIGH);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MAC, DRAIN, WRITE, DONE} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] ip;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] prev;
    logic [ADDR_W-1:0] n_cur;
    logic [ADDR_W-1:0] i_cnt;
    logic [ADDR_W-1:0] j_cnt;
    logic              layer_odd;
    logic signed [ACC_W-1:0] acc;

    logic [ADDR_W-1:0] read_base, write_base;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    shifted;
    logic [DATA_W-1:0]          act;
    logic mac_last, neuron_last, eng_wr_en;

    // Odd layers read the low bank; the bank flips only when a layer really completes.
    assign read_base   = layer_odd ? BASE_LO : BASE_HI;
    assign write_base  = layer_odd ? BASE_HI : BASE_LO;
    assign prod        = $signed(mem.weight_data) * $signed(mem.nram_rd_data);
    assign prod_ext    = {{ADDR_W{prod[2*DATA_W-1]}}, prod};
    assign shifted     = acc >>> FRAC_BITS;
    assign mac_last    = (i_cnt + ADDR_W'(1)) >= prev;
    assign neuron_last = (j_cnt + ADDR_W'(1)) >= n_cur;

    always_comb begin
        act = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            act = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            act = SAT_MIN[DATA_W-1:0];
        end
`ifdef NEURAL_LAYER_ENGINE_RELU_EN
        if (shifted < 0) begin
            act = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        eng_wr_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                busy = 1'b1;
                if (mem.instr_data == END_OF_PROGRAM || ip == '1) begin
                    state_next = DONE;
                end else if (ip == '0 || mem.instr_data == '0) begin
                    state_next = FETCH;
                end else begin
                    state_next = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (mac_last) state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                eng_wr_en  = 1'b1;
                state_next = neuron_last ? FETCH : MAC;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip           <= '0;
            wptr         <= '0;
            prev         <= '0;
            n_cur        <= '0;
            i_cnt        <= '0;
            j_cnt        <= '0;
            layer_odd    <= 1'b1;
            acc          <= '0;
            result_base  <= BASE_LO;
            result_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ip           <= '0;
                        wptr         <= '0;
                        prev         <= '0;
                        layer_odd    <= 1'b1;
                        result_base  <= BASE_LO;
                        result_count <= '0;
                    end
                end
                DECODE: begin
                    if (state_next == MAC) begin
                        n_cur <= mem.instr_data;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end else if (state_next == FETCH) begin
                        ip <= ip + ADDR_W'(1);
                        // Instruction 0 is the input-layer size; it is the result until a layer runs.
                        if (ip == '0) begin
                            prev         <= mem.instr_data;
                            result_count <= mem.instr_data;
                        end
                    end
                end
                MAC: begin
                    // Read data lags the address by one cycle, so cycle 0 only clears.
                    acc   <= (i_cnt == '0) ? '0 : acc + prod_ext;
                    wptr  <= wptr + ADDR_W'(1);
                    i_cnt <= i_cnt + ADDR_W'(1);
                end
                DRAIN: begin
                    acc <= acc + prod_ext;
                end
                WRITE: begin
                    i_cnt <= '0;
                    if (neuron_last) begin
                        prev         <= n_cur;
                        result_base  <= write_base;
                        result_count <= n_cur;
                        ip           <= ip + ADDR_W'(1);
                        layer_odd    <= ~layer_odd;
                    end else begin
                        j_cnt <= j_cnt + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.instr_addr   = ip;
    assign mem.weight_addr  = wptr;
    assign mem.nram_rd_addr = busy ? read_base + i_cnt : ext_rd_addr;
    assign mem.nram_wr_addr = busy ? write_base + j_cnt : ext_wr_addr;
    assign mem.nram_wr_data = busy ? act : ext_wr_data;
    assign mem.nram_wr_en   = busy ? eng_wr_en : ext_wr_en;
    assign ext_rd_data      = mem.nram_rd_data;
endmodule

// File: tb/tb_neural_layer_engine.sv
// tb/tb_neural_layer_engine.sv - directed self-checking bench for neural_layer_engine
module tb_neural_layer_engine;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam logic [AW-1:0] EOP = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done;
    logic [AW-1:0] ext_rd_addr, ext_wr_addr;
    logic [DW-1:0] ext_wr_data, ext_rd_data;
    logic          ext_wr_en;
    logic [AW-1:0] result_base, result_count;

    logic [AW-1:0] irom [256];
    logic [DW-1:0] wrom [256];
    logic [DW-1:0] nram [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neural_layer_engine_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

    neural_layer_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .mem          (mem_bus.master),
        .ext_rd_addr  (ext_rd_addr),
        .ext_wr_addr  (ext_wr_addr),
        .ext_wr_data  (ext_wr_data),
        .ext_wr_en    (ext_wr_en),
        .ext_rd_data  (ext_rd_data),
        .result_base  (result_base),
        .result_count (result_count)
    );

    always @(posedge clk) begin
        mem_bus.instr_data   <= irom[mem_bus.instr_addr];
        mem_bus.weight_data  <= wrom[mem_bus.weight_addr];
        mem_bus.nram_rd_data <= nram[mem_bus.nram_rd_addr];
        if (mem_bus.nram_wr_en) nram[mem_bus.nram_wr_addr] <= mem_bus.nram_wr_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ext_wr_addr = a; ext_wr_data = d; ext_wr_en = 1'b1;
        @(negedge clk);
        ext_wr_en = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        ext_rd_addr = a;
        @(negedge clk);
        d = ext_rd_data;
    endtask

    task automatic load_prog(input logic [AW-1:0] p0, input logic [AW-1:0] p1,
                             input logic [AW-1:0] p2, input logic [AW-1:0] p3);
        for (int k = 0; k < 256; k++) irom[k] = EOP;
        irom[0] = p0; irom[1] = p1; irom[2] = p2; irom[3] = p3;
    endtask

    // Pulses start and counts cycles (negedge samples) until done; optionally pokes the host write port while busy.
    task automatic run_prog(input int max_cyc, input bit poke,
                            output int lat, output int pulses, output logic busy1);
        lat = 0; pulses = 0; busy1 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) busy1 = busy;
            if (poke && c == 1) begin
                ext_wr_addr = 8'd20; ext_wr_data = 8'h77; ext_wr_en = 1'b1;
            end
            if (poke && c == 4) ext_wr_en = 1'b0;
            if (done) begin
                if (lat == 0) lat = c;
                pulses++;
            end else if (lat != 0) begin
                break;
            end
        end
        ext_wr_en = 1'b0;
        check_eq("run_timeout", (lat == 0), 1'b0);
    endtask

    logic [DW-1:0] rd;
    int   lat, pulses;
    logic busy1;

    initial begin
        reset = 1'b1; start = 1'b0;
        ext_rd_addr = '0; ext_wr_addr = '0; ext_wr_data = '0; ext_wr_en = 1'b0;
        for (int k = 0; k < 256; k++) begin
            irom[k] = EOP; wrom[k] = '0; nram[k] = '0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_wr_en", mem_bus.nram_wr_en, 1'b0);
        check_eq("rst_result_base", result_base, 8'd0);
        check_eq("rst_result_count", result_count, 8'd0);
        reset = 1'b0;

        // 3*2 + 4*5 = 26 into bank high
        host_write(8'd0, 8'd3);
        host_write(8'd1, 8'd4);
        load_prog(8'd2, 8'd1, EOP, EOP);
        wrom[0] = 8'd2; wrom[1] = 8'd5;
        run_prog(200, 1'b0, lat, pulses, busy1);
        check_eq("basic_busy_after_start", busy1, 1'b1);
        check_eq("basic_latency", lat, 11);
        check_eq("basic_done_pulses", pulses, 1);
        host_read(8'd20, rd);
        check_eq("basic_value", rd, 8'd26);
        check_eq("basic_result_base", result_base, 8'd20);
        check_eq("basic_result_count", result_count, 8'd1);

        // skipped layer, host write attempt while busy must be ignored
        load_prog(8'd2, 8'd0, EOP, EOP);
        run_prog(200, 1'b1, lat, pulses, busy1);
        check_eq("skip_latency", lat, 7);
        host_read(8'd20, rd);
        check_eq("busy_ext_write_blocked", rd, 8'd26);
        check_eq("skip_result_base", result_base, 8'd0);
        check_eq("skip_result_count", result_count, 8'd2);

        // empty program
        load_prog(EOP, EOP, EOP, EOP);
        run_prog(50, 1'b0, lat, pulses, busy1);
        check_eq("empty_latency", lat, 3);
        check_eq("empty_done_pulses", pulses, 1);
        check_eq("empty_result_count", result_count, 8'd0);
        check_eq("empty_result_base", result_base, 8'd0);

        // positive saturation: 2*127*127 -> 127
        host_write(8'd0, 8'd127);
        host_write(8'd1, 8'd127);
        load_prog(8'd2, 8'd1, EOP, EOP);
        wrom[0] = 8'd127; wrom[1] = 8'd127;
        run_prog(200, 1'b0, lat, pulses, busy1);
        host_read(8'd20, rd);
        check_eq("sat_value", rd, 8'd127);

        // 3*(-2) + 4*0 = -6
        host_write(8'd0, 8'd3);
        host_write(8'd1, 8'd4);
        wrom[0] = 8'hFE; wrom[1] = 8'd0;
        run_prog(200, 1'b0, lat, pulses, busy1);
        host_read(8'd20, rd);
`ifdef NEURAL_LAYER_ENGINE_RELU_EN
        check_eq("neg_value", rd, 8'h00);
`else
        check_eq("neg_value", rd, 8'hFA);
`endif

        // two layers: 26 to bank high, then 26*3 = 78 back to bank low
        load_prog(8'd2, 8'd1, 8'd1, EOP);
        wrom[0] = 8'd2; wrom[1] = 8'd5; wrom[2] = 8'd3;
        run_prog(200, 1'b0, lat, pulses, busy1);
        host_read(8'd20, rd);
        check_eq("two_layer_l1", rd, 8'd26);
        host_read(8'd0, rd);
        check_eq("two_layer_l2", rd, 8'd78);
        check_eq("two_layer_result_base", result_base, 8'd0);
        check_eq("two_layer_result_count", result_count, 8'd1);

        // 3x4 layer, reset in the second neuron's MAC
        host_write(8'd0, 8'd1);
        host_write(8'd1, 8'd2);
        host_write(8'd2, 8'd3);
        host_write(8'd21, 8'h55);
        load_prog(8'd3, 8'd4, EOP, EOP);
        wrom[0] = 8'd1;  wrom[1] = 8'd1;  wrom[2]  = 8'd1;
        wrom[3] = 8'd2;  wrom[4] = 8'd0;  wrom[5]  = 8'hFF;
        wrom[6] = 8'hFF; wrom[7] = 8'hFF; wrom[8]  = 8'hFF;
        wrom[9] = 8'd10; wrom[10] = 8'd10; wrom[11] = 8'd10;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("mid_run_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("abort_wr_en", mem_bus.nram_wr_en, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        host_read(8'd21, rd);
        check_eq("abort_no_write", rd, 8'h55);
        run_prog(200, 1'b0, lat, pulses, busy1);
        host_read(8'd20, rd);
        check_eq("restart_n0", rd, 8'd6);
        host_read(8'd21, rd);
`ifdef NEURAL_LAYER_ENGINE_RELU_EN
        check_eq("restart_n1", rd, 8'h00);
`else
        check_eq("restart_n1", rd, 8'hFF);
`endif
        host_read(8'd22, rd);
`ifdef NEURAL_LAYER_ENGINE_RELU_EN
        check_eq("restart_n2", rd, 8'h00);
`else
        check_eq("restart_n2", rd, 8'hFA);
`endif
        host_read(8'd23, rd);
        check_eq("restart_n3", rd, 8'd60);
        check_eq("restart_result_base", result_base, 8'd20);
        check_eq("restart_result_count", result_count, 8'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neural_layer_engine.md
NEURAL_LAYER_ENGINE -- requirements
Module: neural_layer_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed width of neuron values and weights.
REQ-002 SHALL have parameter ADDR_W, default 8: width of every memory address and of layer sizes.
REQ-003 SHALL have parameter FRAC_BITS, default 0: accumulator right-shift applied before output.
REQ-004 SHALL have parameters RW_BASE_LOW, default 0, and RW_BASE_HIGH, default 20: the two ping-pong neuron bank bases.
REQ-005 SHALL have parameter END_OF_PROGRAM, default all ones (ADDR_W bits): program terminator.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle run request; honoured only when busy=0.
REQ-009 busy  out  1  high from the cycle after start is accepted until done.
REQ-010 done  out  1  one-cycle pulse when the program ends.
REQ-011 instr_addr out ADDR_W / instr_data in ADDR_W: instruction ROM port, 1-cycle read latency.
REQ-012 weight_addr out ADDR_W / weight_data in DATA_W: weight ROM port, 1-cycle read latency.
REQ-013 nram_rd_addr out ADDR_W / nram_rd_data in DATA_W: neuron RAM read port, 1-cycle read latency.
REQ-014 nram_wr_addr out ADDR_W / nram_wr_data out DATA_W / nram_wr_en out 1: neuron RAM write port.
REQ-015 ext_rd_addr, ext_wr_addr in ADDR_W / ext_wr_data in DATA_W / ext_wr_en in 1 / ext_rd_data out DATA_W: host access.
REQ-016 result_base out ADDR_W / result_count out ADDR_W: location and size of the last completed layer.

Function
REQ-017 SHALL use FSM states IDLE, FETCH, DECODE, MAC, DRAIN, WRITE, DONE; IDLE->FETCH on start&!busy; start while busy ignored.
REQ-018 FETCH SHALL drive instr_addr=ip; DECODE SHALL capture instr_data one cycle later.
REQ-019 Instruction 0 SHALL be the input-layer size (prev); each later instruction SHALL be a layer size Nk.
REQ-020 DECODE: Nk==END_OF_PROGRAM or ip==2^ADDR_W-1 -> DONE; Nk==0 -> skip (ip+1, FETCH, no writes, no bank swap); else -> MAC.
REQ-021 Layer k (k>=1) SHALL read bank RW_BASE_LOW when k odd, RW_BASE_HIGH when k even, and write the other bank.
REQ-022 MAC SHALL issue prev consecutive reads (read_base+i, weight pointer) for i=0..prev-1, one per cycle; weight pointer SHALL persist across neurons and layers, starting at 0.
REQ-023 Accumulator SHALL be signed, 2*DATA_W+ADDR_W bits, cleared at start of each neuron; products signed DATA_W x DATA_W.
REQ-024 DRAIN (1 cycle) SHALL absorb the last product; WRITE SHALL assert nram_wr_en for exactly one cycle at write_base+j.
REQ-025 Written value SHALL be accumulator >>> FRAC_BITS saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-026 Each neuron SHALL take prev+2 cycles; after neuron Nk-1, prev<=Nk, result_base<=write_base, result_count<=Nk, ip+1, FETCH.
REQ-027 DONE SHALL pulse done for one cycle, clear busy the same cycle, return to IDLE; a program with no layers SHALL leave result_base=RW_BASE_LOW, result_count=prev.
REQ-028 When busy=0, neuron RAM ports SHALL be driven from ext_* signals; when busy=1, ext_wr_en SHALL be ignored and ext_rd_data SHALL read as internal nram_rd_data.

Reset
REQ-029 On reset: state IDLE, ip=0, weight pointer=0, accumulator=0, busy=0, done=0, nram_wr_en=0, result_base=RW_BASE_LOW, result_count=0.
REQ-030 Reset mid-run SHALL abort immediately with no further neuron writes; a new start SHALL restart from ip 0.

Configuration
REQ-031 Macro NEURAL_LAYER_ENGINE_RELU_EN defined: negative saturated results SHALL be written as 0.
REQ-032 Macro undefined: saturated results SHALL be written unchanged (linear activation).

Verification
REQ-033 Host writes 3,4 at addresses 0,1; program [2,1,END]; weights [2,5] -> 26 written at 20, result_base=20, result_count=1, done pulses once.
REQ-034 Inputs 127,127; program [2,1,END]; weights [127,127] -> written 127 (saturated).
REQ-035 Inputs 3,4; program [2,1,END]; weights [-2,0] -> 0 with RELU_EN, -6 (0xFA) without.
REQ-036 Reset asserted mid-MAC of a 3x4 layer -> nram_wr_en=0 immediately, busy=0; restart yields same results as an unbroken run.
REQ-037 ext_wr_en=1 to address 20 while busy -> RAM unchanged; program [END] -> done 3 cycles after start, result_count=0.
